data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter: ADDR_BITS, default 10, word-address width (memory depth 2^ADDR_BITS 32-bit words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 MemRead  input  2  read size: 00 none, 01 byte, 10 halfword, 11 word.
REQ-005 MemWrite  input  2  write size: 00 none, 01 byte (sb), 10 halfword (sh), 11 word (sw).
REQ-006 Unsigned  input  1  read extension: 1 zero-extend, 0 sign-extend (lbu/lhu vs lb/lh).
REQ-007 Addr  input  32  byte address from CPU ALU result.
REQ-008 WriteData  input  32  store data; low byte/halfword used for sb/sh.
REQ-009 MEMdataOut  output  32  extended load data to CPU write-back mux.
REQ-010 AlignErr  output  1  sticky misaligned-access flag.
REQ-011 ErrAddr  output  32  byte address of first misaligned access since reset.
REQ-012 ErrCount  output  8  count of misaligned accesses since reset.

Function
REQ-013 Storage SHALL be 2^ADDR_BITS words, indexed by Addr[ADDR_BITS+1:2]; Addr bits above ADDR_BITS+1 ignored (address wraps modulo depth).
REQ-014 Byte order SHALL be little-endian: byte lane k = Addr[1:0]==k occupies word bits [8k+7:8k]; halfword at Addr[1]=h occupies bits [16h+15:16h].
REQ-015 Alignment: byte always aligned; halfword requires Addr[0]==0; word requires Addr[1:0]==00.
REQ-016 Reads SHALL be combinational: MEMdataOut reflects current array contents, Addr, MemRead, Unsigned in the same cycle (zero latency).
REQ-017 MemRead==00 or misaligned read SHALL drive MEMdataOut = 0.
REQ-018 Byte/halfword reads SHALL extend selected lane to 32 bits per Unsigned; word reads ignore Unsigned.
REQ-019 Aligned writes SHALL update only the addressed lane(s) on the rising clk edge; other lanes unchanged.
REQ-020 Misaligned writes SHALL be suppressed (no lane modified).
REQ-021 Simultaneous non-zero MemRead and MemWrite: write commits at the edge; MEMdataOut during that cycle shows pre-write contents.
REQ-022 Each cycle with a misaligned read or write (counted once per cycle even if both) SHALL, at the edge, set AlignErr=1 and increment ErrCount.
REQ-023 ErrCount SHALL saturate at 255 (no wrap).
REQ-024 ErrAddr SHALL latch Addr only on the edge where AlignErr transitions 0->1; later faults do not overwrite it.
REQ-025 AlignErr SHALL remain 1 until reset; no other clear mechanism.

Reset
REQ-026 rst asserted SHALL immediately (without clk) clear all memory words to 0, AlignErr=0, ErrAddr=0, ErrCount=0.
REQ-027 While rst is high, writes and fault updates SHALL be ignored; MEMdataOut reads as 0 for any address.
REQ-028 rst deasserting mid-cycle SHALL not cause a write on that cycle's pending edge unless rst is low at the edge.

Verification
REQ-029 Reset then sw 0x8BADF00D @0x10; lw @0x10 -> MEMdataOut=0x8BADF00D; lw @0x14 -> 0x00000000.
REQ-030 After REQ-029: lb @0x13 -> 0xFFFFFF8B; lbu @0x13 -> 0x0000008B; lh @0x10 -> 0xFFFFF00D; lhu @0x12 -> 0x00008BAD.
REQ-031 sb 0x000000AA @0x11 then lw @0x10 -> 0x8BADAA0D; sh 0x00001234 @0x12 then lw @0x10 -> 0x1234AA0D.
REQ-032 sw 0xFFFFFFFF @0x22 -> word @0x20 unchanged (0), AlignErr=1, ErrAddr=0x22, ErrCount=1; lh @0x31 -> MEMdataOut=0, ErrCount=2, ErrAddr still 0x22.
REQ-033 Same cycle MemRead=11, MemWrite=11, Addr=0x40, WriteData=0x5A5A5A5A on zeroed word -> MEMdataOut=0 that cycle, 0x5A5A5A5A next cycle; Addr=0x1040 (ADDR_BITS=10) reads same word.
REQ-034 Assert rst asynchronously between edges after REQ-031 -> outputs and lw @0x10 read 0 before next clk edge; 260 misaligned cycles -> ErrCount=255.

Source files
------------

// File: rtl/data_memory.sv
// data_memory: byte-addressable little-endian data RAM with sized loads/stores and misalignment tracking
module data_memory #(
   parameter int ADDR_BITS = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  MemRead,
   input  logic [1:0]  MemWrite,
   input  logic        Unsigned,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] MEMdataOut,
   output logic        AlignErr,
   output logic [31:0] ErrAddr,
   output logic [7:0]  ErrCount
);

   logic [31:0] mem [2**ADDR_BITS];
   logic [ADDR_BITS-1:0] wordIdx;
   logic [31:0] curWord, laneShift, wrData;
   logic [7:0]  byteVal;
   logic [15:0] halfVal;
   logic [3:0]  wrMask;
   logic        rdBad, wrBad, fault, unusedAddr;

   // Address bits above the array depth wrap silently.
   assign unusedAddr = ^Addr[31:ADDR_BITS+2];
   assign wordIdx    = Addr[ADDR_BITS+1:2];
   assign curWord    = mem[wordIdx];
   assign laneShift  = curWord >> {Addr[1:0], 3'b000};
   assign byteVal    = laneShift[7:0];
   assign halfVal    = Addr[1] ? curWord[31:16] : curWord[15:0];

   // Alignment checks, extended load mux and store lane mask.
   always_comb begin
      rdBad      = (MemRead == 2'b10) ? Addr[0] : (MemRead == 2'b11) ? |Addr[1:0] : 1'b0;
      wrBad      = (MemWrite == 2'b10) ? Addr[0] : (MemWrite == 2'b11) ? |Addr[1:0] : 1'b0;
      fault      = rdBad | wrBad;
      MEMdataOut = (rst || MemRead == 2'b00 || rdBad) ? 32'h0 :
                   (MemRead == 2'b01) ? {{24{~Unsigned & byteVal[7]}}, byteVal} :
                   (MemRead == 2'b10) ? {{16{~Unsigned & halfVal[15]}}, halfVal} : curWord;
      wrData     = (MemWrite == 2'b01) ? {4{WriteData[7:0]}} :
                   (MemWrite == 2'b10) ? {2{WriteData[15:0]}} : WriteData;
      wrMask     = wrBad ? 4'b0000 :
                   (MemWrite == 2'b01) ? 4'b0001 << Addr[1:0] :
                   (MemWrite == 2'b10) ? (Addr[1] ? 4'b1100 : 4'b0011) :
                   (MemWrite == 2'b11) ? 4'b1111 : 4'b0000;
   end

   // Storage: async clear, per-lane write on the rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mem <= '{default: '0};
      else for (int k = 0; k < 4; k++) if (wrMask[k]) mem[wordIdx][8*k +: 8] <= wrData[8*k +: 8];
   end

   // Sticky fault flag, first-fault address and saturating fault counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         AlignErr <= 1'b0;
         ErrAddr  <= 32'h0;
         ErrCount <= 8'h0;
      end else if (fault) begin
         AlignErr <= 1'b1;
         if (!AlignErr) ErrAddr <= Addr;
         if (ErrCount != 8'hFF) ErrCount <= ErrCount + 8'h1;
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed self-checking bench for data_memory
module tb_data_memory;

   logic        clk, rst, Unsigned;
   logic [1:0]  MemRead, MemWrite;
   logic [31:0] Addr, WriteData, MEMdataOut, ErrAddr;
   logic        AlignErr;
   logic [7:0]  ErrCount;
   int checks = 0;
   int fails = 0;

   data_memory #(.ADDR_BITS(10)) dut (
      .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Unsigned(Unsigned),
      .Addr(Addr), .WriteData(WriteData), .MEMdataOut(MEMdataOut), .AlignErr(AlignErr),
      .ErrAddr(ErrAddr), .ErrCount(ErrCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [1:0] rd, input logic [1:0] wr, input logic uns,
                        input logic [31:0] a, input logic [31:0] d);
      MemRead = rd; MemWrite = wr; Unsigned = uns; Addr = a; WriteData = d;
   endtask

   // one clocked store, then inputs return to idle
   task automatic store(input logic [1:0] wr, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk); drive(2'b00, wr, 1'b0, a, d);
      @(posedge clk); #1 drive(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
   endtask

   // combinational load sampled away from any edge
   task automatic peek(input logic [1:0] rd, input logic uns, input logic [31:0] a);
      @(negedge clk); drive(rd, 2'b00, uns, a, 32'h0); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(2'b11, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF);
      @(posedge clk); #1;
      checks++; if (MEMdataOut !== 32'h0) begin fails++; $display("FAIL reset_read got %h want %h", MEMdataOut, 32'h0); end
      @(negedge clk); drive(2'b11, 2'b11, 1'b0, 32'h13, 32'hFFFFFFFF);
      @(posedge clk); #1;
      checks++; if (AlignErr !== 1'b0) begin fails++; $display("FAIL reset_alignerr got %b want 0", AlignErr); end
      checks++; if (ErrCount !== 8'h0) begin fails++; $display("FAIL reset_errcount got %h want 00", ErrCount); end
      checks++; if (ErrAddr !== 32'h0) begin fails++; $display("FAIL reset_erraddr got %h want 0", ErrAddr); end
      @(negedge clk); rst = 1'b0; drive(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
      peek(2'b11, 1'b0, 32'h10);
      checks++; if (MEMdataOut !== 32'h0) begin fails++; $display("FAIL reset_write_ignored got %h want 0", MEMdataOut); end
   endtask

   task automatic test_word;
      store(2'b11, 32'h10, 32'h8BADF00D);
      peek(2'b11, 1'b0, 32'h10);
      checks++; if (MEMdataOut !== 32'h8BADF00D) begin fails++; $display("FAIL lw_0x10 got %h want 8badf00d", MEMdataOut); end
      peek(2'b11, 1'b1, 32'h10);
      checks++; if (MEMdataOut !== 32'h8BADF00D) begin fails++; $display("FAIL lw_uns_0x10 got %h want 8badf00d", MEMdataOut); end
      peek(2'b11, 1'b0, 32'h14);
      checks++; if (MEMdataOut !== 32'h0) begin fails++; $display("FAIL lw_0x14 got %h want 0", MEMdataOut); end
      peek(2'b00, 1'b0, 32'h10);
      checks++; if (MEMdataOut !== 32'h0) begin fails++; $display("FAIL noread got %h want 0", MEMdataOut); end
   endtask

   task automatic test_subword;
      peek(2'b01, 1'b0, 32'h13);
      checks++; if (MEMdataOut !== 32'hFFFFFF8B) begin fails++; $display("FAIL lb_0x13 got %h want ffffff8b", MEMdataOut); end
      peek(2'b01, 1'b1, 32'h13);
      checks++; if (MEMdataOut !== 32'h0000008B) begin fails++; $display("FAIL lbu_0x13 got %h want 0000008b", MEMdataOut); end
      peek(2'b01, 1'b0, 32'h10);
      checks++; if (MEMdataOut !== 32'h0000000D) begin fails++; $display("FAIL lb_0x10 got %h want 0000000d", MEMdataOut); end
      peek(2'b01, 1'b0, 32'h11);
      checks++; if (MEMdataOut !== 32'hFFFFFFF0) begin fails++; $display("FAIL lb_0x11 got %h want fffffff0", MEMdataOut); end
      peek(2'b10, 1'b0, 32'h10);
      checks++; if (MEMdataOut !== 32'hFFFFF00D) begin fails++; $display("FAIL lh_0x10 got %h want fffff00d", MEMdataOut); end
      peek(2'b10, 1'b1, 32'h12);
      checks++; if (MEMdataOut !== 32'h00008BAD) begin fails++; $display("FAIL lhu_0x12 got %h want 00008bad", MEMdataOut); end
      peek(2'b10, 1'b0, 32'h12);
      checks++; if (MEMdataOut !== 32'hFFFF8BAD) begin fails++; $display("FAIL lh_0x12 got %h want ffff8bad", MEMdataOut); end
   endtask

   task automatic test_partial_write;
      store(2'b01, 32'h11, 32'h000000AA);
      peek(2'b11, 1'b0, 32'h10);
      checks++; if (MEMdataOut !== 32'h8BADAA0D) begin fails++; $display("FAIL sb_0x11 got %h want 8badaa0d", MEMdataOut); end
      store(2'b10, 32'h12, 32'h00001234);
      peek(2'b11, 1'b0, 32'h10);
      checks++; if (MEMdataOut !== 32'h1234AA0D) begin fails++; $display("FAIL sh_0x12 got %h want 1234aa0d", MEMdataOut); end
      store(2'b01, 32'h14, 32'hFFFFFF77);
      peek(2'b11, 1'b0, 32'h14);
      checks++; if (MEMdataOut !== 32'h00000077) begin fails++; $display("FAIL sb_0x14 got %h want 00000077", MEMdataOut); end
      checks++; if (AlignErr !== 1'b0) begin fails++; $display("FAIL aligned_no_err got %b want 0", AlignErr); end
   endtask

   task automatic test_misaligned;
      store(2'b11, 32'h22, 32'hFFFFFFFF);
      peek(2'b11, 1'b0, 32'h20);
      checks++; if (MEMdataOut !== 32'h0) begin fails++; $display("FAIL sw_mis_suppressed got %h want 0", MEMdataOut); end
      checks++; if (AlignErr !== 1'b1) begin fails++; $display("FAIL mis_alignerr got %b want 1", AlignErr); end
      checks++; if (ErrAddr !== 32'h22) begin fails++; $display("FAIL mis_erraddr got %h want 00000022", ErrAddr); end
      checks++; if (ErrCount !== 8'd1) begin fails++; $display("FAIL mis_errcount1 got %0d want 1", ErrCount); end
      @(negedge clk); drive(2'b10, 2'b00, 1'b0, 32'h31, 32'h0); #1;
      checks++; if (MEMdataOut !== 32'h0) begin fails++; $display("FAIL lh_mis_read got %h want 0", MEMdataOut); end
      @(posedge clk); #1;
      checks++; if (ErrCount !== 8'd2) begin fails++; $display("FAIL mis_errcount2 got %0d want 2", ErrCount); end
      checks++; if (ErrAddr !== 32'h22) begin fails++; $display("FAIL erraddr_kept got %h want 00000022", ErrAddr); end
      @(negedge clk); drive(2'b11, 2'b10, 1'b0, 32'h35, 32'hBEEF);
      @(posedge clk); #1 drive(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
      checks++; if (ErrCount !== 8'd3) begin fails++; $display("FAIL both_mis_once got %0d want 3", ErrCount); end
      peek(2'b11, 1'b0, 32'h34);
      checks++; if (MEMdataOut !== 32'h0) begin fails++; $display("FAIL sh_mis_suppressed got %h want 0", MEMdataOut); end
   endtask

   task automatic test_back_to_back;
      @(negedge clk); drive(2'b11, 2'b11, 1'b0, 32'h40, 32'h5A5A5A5A); #1;
      checks++; if (MEMdataOut !== 32'h0) begin fails++; $display("FAIL rw_prewrite got %h want 0", MEMdataOut); end
      @(posedge clk); #1;
      checks++; if (MEMdataOut !== 32'h5A5A5A5A) begin fails++; $display("FAIL rw_postwrite got %h want 5a5a5a5a", MEMdataOut); end
      @(negedge clk); drive(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
      peek(2'b11, 1'b0, 32'h1040);
      checks++; if (MEMdataOut !== 32'h5A5A5A5A) begin fails++; $display("FAIL wrap_0x1040 got %h want 5a5a5a5a", MEMdataOut); end
   endtask

   task automatic test_async_reset;
      peek(2'b11, 1'b0, 32'h10);
      checks++; if (MEMdataOut !== 32'h1234AA0D) begin fails++; $display("FAIL pre_reset got %h want 1234aa0d", MEMdataOut); end
      rst = 1'b1; #1;
      checks++; if (MEMdataOut !== 32'h0) begin fails++; $display("FAIL async_read got %h want 0", MEMdataOut); end
      checks++; if (AlignErr !== 1'b0) begin fails++; $display("FAIL async_alignerr got %b want 0", AlignErr); end
      checks++; if (ErrCount !== 8'h0) begin fails++; $display("FAIL async_errcount got %h want 00", ErrCount); end
      checks++; if (ErrAddr !== 32'h0) begin fails++; $display("FAIL async_erraddr got %h want 0", ErrAddr); end
      rst = 1'b0; #1;
      checks++; if (MEMdataOut !== 32'h0) begin fails++; $display("FAIL async_mem_cleared got %h want 0", MEMdataOut); end
      peek(2'b11, 1'b0, 32'h40);
      checks++; if (MEMdataOut !== 32'h0) begin fails++; $display("FAIL async_mem_cleared2 got %h want 0", MEMdataOut); end
   endtask

   task automatic test_saturation;
      @(negedge clk); drive(2'b10, 2'b00, 1'b0, 32'h1, 32'h0);
      repeat (260) @(posedge clk);
      #1 drive(2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
      checks++; if (ErrCount !== 8'd255) begin fails++; $display("FAIL sat_errcount got %0d want 255", ErrCount); end
      checks++; if (AlignErr !== 1'b1) begin fails++; $display("FAIL sat_alignerr got %b want 1", AlignErr); end
      checks++; if (ErrAddr !== 32'h1) begin fails++; $display("FAIL sat_erraddr got %h want 00000001", ErrAddr); end
   endtask

   initial begin
      test_reset;
      test_word;
      test_subword;
      test_partial_write;
      test_misaligned;
      test_back_to_back;
      test_async_reset;
      test_saturation;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
